// File: rtl/rgb565_frame_reader.sv
// ---------------------------------------------------------------------------
// rgb565_frame_reader
//
// Reads one complete RGB565 frame from the frame-buffer memory, one 16-bit
// pixel per address in raster order. Each pixel is expanded to RGB888 by bit
// replication and streamed out with valid/ready flow control. The stream
// carries start-of-frame, end-of-line and end-of-frame markers.
//
// The memory has a 1-cycle synchronous read latency. A 2-entry output buffer
// hides that latency. A word arriving from memory is presented directly when
// the buffer is empty, so a sink that is always ready receives one pixel per
// cycle.
//
// Ports
//   iClk           clock (single domain)
//   iRst           synchronous, active-high reset
//   i_Clk_en       clock enable; when low every register holds, except the
//                  capture of a read issued on the previous enabled cycle
//   i_start        pulse; starts a frame read from address 0 when idle
//   o_rd_en        memory read strobe
//   o_addr         memory read address
//   i_rd_data      memory read data {R5,G6,B5}, valid 1 cycle after o_rd_en
//   o_data_rgb888  expanded pixel: R[23:16], G[15:8], B[7:0]
//   o_valid        output pixel valid
//   i_ready        sink ready; a transfer is o_valid & i_ready & i_Clk_en
//   o_sof          marks pixel 0 of the frame
//   o_eol          marks the last pixel of each line
//   o_eof          marks the last pixel of the frame
//   o_busy         high while a frame is being read
//   o_done         one-cycle pulse after the last pixel transfers
// ---------------------------------------------------------------------------
module rgb565_frame_reader #(
  parameter int IMG_WIDTH  = 480,
  parameter int IMG_HEIGHT = 272,
  parameter int MEM_DEPTH  = 130560,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  i_Clk_en,
  input  logic                  i_start,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [23:0]           o_data_rgb888,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sof,
  output logic                  o_eol,
  output logic                  o_eof,
  output logic                  o_busy,
  output logic                  o_done
);

  // If the geometry and the memory depth ever disagree, read no more than
  // the smaller of the two. This keeps reads inside the memory and keeps the
  // eof marker on a pixel that really exists.
  localparam int FRAME_PIXELS = (IMG_WIDTH * IMG_HEIGHT < MEM_DEPTH) ?
                                (IMG_WIDTH * IMG_HEIGHT) : MEM_DEPTH;

  // The address counter has one extra bit so that it can sit at
  // FRAME_PIXELS after the last issue without wrapping.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [CNT_W-1:0] END_ADDR   = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_WIDTH - 1);

  // Buffer entry layout: {sof, eol, eof, rgb888}
  localparam int ENTRY_W = 27;
  localparam int SOF_BIT = 26;
  localparam int EOL_BIT = 25;
  localparam int EOF_BIT = 24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]   rd_addr;
  logic               in_flight;
  logic [CNT_W-1:0]   arr_cnt;
  logic [COL_W-1:0]   arr_col;
  logic [1:0]         buf_count;
  logic [ENTRY_W-1:0] slot0;
  logic [ENTRY_W-1:0] slot1;

  logic [4:0]         red5;
  logic [5:0]         green6;
  logic [4:0]         blue5;
  logic [23:0]        expanded;
  logic [ENTRY_W-1:0] arr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               head_valid;
  logic [1:0]         occupancy;
  logic               start_go;
  logic               pop;
  logic               bypass;
  logic               pop_buf;
  logic               push;

  // Expansion by bit replication: the top bits of each field are copied into
  // the new low bits. Full scale maps to 0xFF and zero maps to 0x00.
  assign red5     = i_rd_data[15:11];
  assign green6   = i_rd_data[10:5];
  assign blue5    = i_rd_data[4:0];
  assign expanded = {red5, red5[4:2], green6, green6[5:4], blue5, blue5[4:2]};

  // Markers for the arriving word come from the arrival-side counters. Words
  // arrive strictly in raster order, so the arrival count is the pixel index.
  assign arr_entry = {(arr_cnt == '0), (arr_col == LAST_COL),
                      (arr_cnt == LAST_PIXEL), expanded};

  // The head of the stream is the oldest buffered word. When the buffer is
  // empty, the head is the word arriving from memory this cycle.
  assign head_valid = (buf_count != 2'd0) | in_flight;
  assign head_entry = (buf_count != 2'd0) ? slot0 : arr_entry;

  assign o_valid       = head_valid;
  assign o_data_rgb888 = head_valid ? head_entry[23:0] : 24'd0;
  assign o_sof         = head_valid & head_entry[SOF_BIT];
  assign o_eol         = head_valid & head_entry[EOL_BIT];
  assign o_eof         = head_valid & head_entry[EOF_BIT];

  // A pop taken straight from the arriving word never enters the buffer.
  assign pop     = head_valid & i_ready & i_Clk_en;
  assign bypass  = pop & (buf_count == 2'd0);
  assign pop_buf = pop & (buf_count != 2'd0);
  assign push    = in_flight & ~bypass;

  // The read in flight already owns a buffer slot. A new read is issued only
  // while fewer than two words are buffered or pending.
  assign occupancy = buf_count + {1'b0, in_flight};
  assign o_rd_en   = (state == RUN) & i_Clk_en & (rd_addr < END_ADDR) &
                     (occupancy < 2'd2);
  assign o_addr    = rd_addr[ADDR_WIDTH-1:0];

  assign start_go = (state == IDLE) & i_start & i_Clk_en;
  assign o_busy   = (state == RUN);
  assign o_done   = (state == DONE);

  // Next-state logic. Every transition needs an enabled cycle: the RUN exit
  // depends on a transfer, and a transfer already includes i_Clk_en.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_go) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (pop & head_entry[EOF_BIT]) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (i_Clk_en) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Track the single outstanding read. This register follows o_rd_en every
  // cycle, even when i_Clk_en is low. That way a read issued on the last
  // enabled cycle is still captured. Reset drops any pending read.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      in_flight <= 1'b0;
    end else begin
      in_flight <= o_rd_en;
    end
  end

  // Read address. It stops at the end of the frame instead of wrapping.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rd_addr <= '0;
    end else if (start_go) begin
      rd_addr <= '0;
    end else if (o_rd_en) begin
      rd_addr <= rd_addr + CNT_W'(1);
    end
  end

  // Arrival-side pixel and column counters. They advance once per captured
  // word, so they stay aligned with the word they label.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      arr_cnt <= '0;
      arr_col <= '0;
    end else if (start_go) begin
      arr_cnt <= '0;
      arr_col <= '0;
    end else if (in_flight) begin
      arr_cnt <= arr_cnt + CNT_W'(1);
      if (arr_col == LAST_COL) begin
        arr_col <= '0;
      end else begin
        arr_col <= arr_col + COL_W'(1);
      end
    end
  end

  // Two-entry buffer; slot0 is always the oldest word. The push with a full
  // buffer case is left out: a push needs a read in flight, and the issue
  // rule never lets two buffered words coexist with one in flight.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      buf_count <= 2'd0;
      slot0     <= '0;
      slot1     <= '0;
    end else if (start_go) begin
      buf_count <= 2'd0;
    end else begin
      unique case ({push, pop_buf})
        2'b10: begin
          if (buf_count == 2'd0) begin
            slot0 <= arr_entry;
          end else begin
            slot1 <= arr_entry;
          end
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          slot0     <= slot1;
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            slot0 <= arr_entry;
          end else begin
            slot0 <= slot1;
            slot1 <= arr_entry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb565_frame_reader.sv
module tb_rgb565_frame_reader;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 16;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          i_Clk_en;
  logic          i_start;
  logic          o_rd_en;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] i_rd_data;
  logic [23:0]   o_data_rgb888;
  logic          o_valid;
  logic          i_ready;
  logic          o_sof;
  logic          o_eol;
  logic          o_eof;
  logic          o_busy;
  logic          o_done;

  rgb565_frame_reader #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .MEM_DEPTH (DEPTH),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .i_Clk_en     (i_Clk_en),
    .i_start      (i_start),
    .o_rd_en      (o_rd_en),
    .o_addr       (o_addr),
    .i_rd_data    (i_rd_data),
    .o_data_rgb888(o_data_rgb888),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sof        (o_sof),
    .o_eol        (o_eol),
    .o_eof        (o_eof),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 iClk = ~iClk;

  // Frame-buffer memory model with a 1-cycle synchronous read.
  logic [15:0] mem [0:DEPTH-1];
  always @(posedge iClk) begin
    if (o_rd_en) begin
      i_rd_data <= mem[o_addr];
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-frame observations gathered by the cycle monitor.
  int          frame_cyc;
  int          issues;
  int          xfers;
  int          first_issue_fc;
  int          first_valid_fc;
  int          first_busy_fc;
  int          last_busy_fc;
  int          done_fc;
  int          done_count;
  logic [23:0] xfer_data [$];
  logic [2:0]  xfer_flags [$];
  int          xfer_fc [$];
  logic        prev_hold;
  logic [26:0] prev_out;
  logic        prev_en;
  logic [AW-1:0] prev_addr;
  logic [23:0] exp_tbl [0:DEPTH-1];

  function automatic logic [23:0] expand(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic start,
                               input logic ready, input logic en);
    iRst     = rst;
    i_start  = start;
    i_ready  = ready;
    i_Clk_en = en;
  endtask

  task automatic clearScoreboard();
    frame_cyc      = 0;
    issues         = 0;
    xfers          = 0;
    first_issue_fc = -1;
    first_valid_fc = -1;
    first_busy_fc  = -1;
    last_busy_fc   = -1;
    done_fc        = -1;
    done_count     = 0;
    xfer_data.delete();
    xfer_flags.delete();
    xfer_fc.delete();
    prev_hold      = 1'b0;
    prev_out       = '0;
    prev_en        = 1'b1;
    prev_addr      = '0;
  endtask

  // Per-cycle protocol checks and transfer capture, sampled at the negedge.
  task automatic monitorCycle();
    if (o_rd_en) begin
      if (first_issue_fc < 0) first_issue_fc = frame_cyc;
      checkOutput("rd_addr_order", 32'(o_addr), 32'(issues));
      issues++;
      checkOutput("outstanding_le_2", 32'(issues - xfers <= 2), 32'd1);
    end
    if (!i_Clk_en) checkOutput("rd_en_gated", 32'(o_rd_en), 32'd0);
    if (!i_Clk_en && !prev_en) checkOutput("addr_frozen", 32'(o_addr), 32'(prev_addr));
    if (prev_hold) begin
      checkOutput("stall_hold", 32'({o_valid, o_sof, o_eol, o_eof, o_data_rgb888}),
                  32'({1'b1, prev_out}));
    end
    if (!o_valid) checkOutput("markers_idle", 32'({o_sof, o_eol, o_eof}), 32'd0);
    if (o_valid && first_valid_fc < 0) first_valid_fc = frame_cyc;
    if (o_busy) begin
      if (first_busy_fc < 0) first_busy_fc = frame_cyc;
      last_busy_fc = frame_cyc;
    end
    if (o_valid && i_ready && i_Clk_en && !iRst) begin
      xfer_data.push_back(o_data_rgb888);
      xfer_flags.push_back({o_sof, o_eol, o_eof});
      xfer_fc.push_back(frame_cyc);
      xfers++;
    end
    if (o_done) begin
      done_count++;
      done_fc = frame_cyc;
    end
    prev_hold = o_valid && !(i_ready && i_Clk_en) && !iRst;
    prev_out  = {o_sof, o_eol, o_eof, o_data_rgb888};
    prev_en   = i_Clk_en;
    prev_addr = o_addr;
    frame_cyc++;
  endtask

  task automatic stepCycle(input logic rst, input logic start,
                           input logic ready, input logic en);
    @(posedge iClk);
    #1;
    applyStimulus(rst, start, ready, en);
    @(negedge iClk);
    monitorCycle();
  endtask

  // Start pulse in frame cycle 0, then run until o_done (or abort after a
  // given number of transfers). A cycle budget bounds the run.
  task automatic runFrame(input logic [15:0] ready_pat, input int en_off_from,
                          input int en_off_len, input int restart_fc,
                          input int abort_after);
    logic rdy;
    logic en;
    logic st;
    clearScoreboard();
    stepCycle(1'b0, 1'b1, ready_pat[0], 1'b1);
    for (int n = 1; n < 200; n++) begin
      if (done_count > 0) break;
      if (abort_after > 0 && xfers >= abort_after) break;
      rdy = ready_pat[n % 16];
      en  = !(n >= en_off_from && n < en_off_from + en_off_len);
      st  = (n == restart_fc);
      stepCycle(1'b0, st, rdy, en);
    end
    if (abort_after == 0) begin
      checkOutput("frame_done_seen", 32'(done_count), 32'd1);
      stepCycle(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("done_one_cycle", 32'({o_done, o_busy}), 32'd0);
    end
  endtask

  task automatic verifyFrame(input string name, input bit use_tbl);
    logic [23:0] exp_data;
    checkOutput({name, "_count"}, 32'(xfers), 32'(DEPTH));
    for (int i = 0; i < xfers && i < DEPTH; i++) begin
      exp_data = use_tbl ? exp_tbl[i] : expand(16'(i * 16'h1111));
      checkOutput({name, "_data"}, 32'(xfer_data[i]), 32'(exp_data));
      checkOutput({name, "_flags"}, 32'(xfer_flags[i]),
                  32'({i == 0, (i % W) == W - 1, i == DEPTH - 1}));
    end
  endtask

  task automatic loadRamp();
    for (int k = 0; k < DEPTH; k++) mem[k] = 16'(k * 16'h1111);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    clearScoreboard();
    loadRamp();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);

    // Reset state
    stepCycle(1'b1, 1'b0, 1'b1, 1'b1);
    stepCycle(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("reset_ctrl", 32'({o_rd_en, o_valid, o_sof, o_eol, o_eof, o_busy, o_done}), 32'd0);
    checkOutput("reset_addr", 32'(o_addr), 32'd0);
    checkOutput("reset_data", 32'(o_data_rgb888), 32'd0);
    stepCycle(1'b0, 1'b0, 1'b1, 1'b1);

    // Ramp frame, sink always ready: one pixel per cycle
    runFrame(16'hFFFF, 1000, 0, -1, 0);
    verifyFrame("ramp", 1'b0);
    checkOutput("ramp_first_issue", 32'(first_issue_fc), 32'd1);
    checkOutput("ramp_first_valid", 32'(first_valid_fc), 32'd2);
    checkOutput("ramp_first_busy", 32'(first_busy_fc), 32'd1);
    checkOutput("ramp_last_busy", 32'(last_busy_fc), 32'd9);
    checkOutput("ramp_done_cycle", 32'(done_fc), 32'd10);
    for (int i = 0; i < xfers && i < DEPTH; i++) begin
      checkOutput("ramp_xfer_cycle", 32'(xfer_fc[i]), 32'(i + 2));
    end

    // Expansion check, hand-computed results
    mem[0] = 16'hF800; exp_tbl[0] = 24'hFF0000;
    mem[1] = 16'h07E0; exp_tbl[1] = 24'h00FF00;
    mem[2] = 16'h001F; exp_tbl[2] = 24'h0000FF;
    mem[3] = 16'hFFFF; exp_tbl[3] = 24'hFFFFFF;
    mem[4] = 16'h0000; exp_tbl[4] = 24'h000000;
    mem[5] = 16'h8410; exp_tbl[5] = 24'h848284;
    mem[6] = 16'h0000; exp_tbl[6] = 24'h000000;
    mem[7] = 16'hFFFF; exp_tbl[7] = 24'hFFFFFF;
    runFrame(16'hFFFF, 1000, 0, -1, 0);
    verifyFrame("expand", 1'b1);

    // Backpressure with an irregular ready pattern
    loadRamp();
    runFrame(16'b0110_0101_1100_1010, 1000, 0, -1, 0);
    verifyFrame("backpressure", 1'b0);

    // Clock enable low for 5 cycles mid-frame: the end moves out by 5
    runFrame(16'hFFFF, 4, 5, -1, 0);
    verifyFrame("clk_en", 1'b0);
    checkOutput("clk_en_done_cycle", 32'(done_fc), 32'd15);

    // Start re-pulsed during RUN is ignored
    runFrame(16'hFFFF, 1000, 0, 4, 0);
    verifyFrame("restart_ignored", 1'b0);
    checkOutput("restart_done_cycle", 32'(done_fc), 32'd10);

    // Reset after pixel 3: abort, no done, then a clean restart
    runFrame(16'hFFFF, 1000, 0, -1, 4);
    checkOutput("abort_xfers", 32'(xfers), 32'd4);
    stepCycle(1'b1, 1'b0, 1'b1, 1'b1);
    stepCycle(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("abort_ctrl", 32'({o_rd_en, o_valid, o_sof, o_eol, o_eof, o_busy, o_done}), 32'd0);
    checkOutput("abort_addr", 32'(o_addr), 32'd0);
    checkOutput("abort_data", 32'(o_data_rgb888), 32'd0);
    repeat (12) stepCycle(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("abort_no_done", 32'(done_count), 32'd0);
    runFrame(16'hFFFF, 1000, 0, -1, 0);
    verifyFrame("after_reset", 1'b0);
    checkOutput("after_reset_done_cycle", 32'(done_fc), 32'd10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
